// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer arbiter.
// Default frame is 320x240 palette-indexed words per bank.
package fb_pkg;

    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_FB_WORDS = 76800;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CLEAR   = 2'd2
    } fb_state_t;

    typedef logic [DEF_ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Sequential word counter that sweeps 0..FB_WORDS-1 of the back bank.
// Counter restarts on start_i and wraps to 0 after the last word.
module fb_clear_engine #(
    parameter int ADDR_W   = 17,
    parameter int FB_WORDS = 76800
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic              last;

    assign last   = (cnt_q == ADDR_W'(FB_WORDS - 1));
    assign addr_o = cnt_q;
    assign done_o = advance_i & last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
        end else if (advance_i) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter with tear-free double-buffer swap.
// Define FB_CLEAR_EN to clear the new back bank after every swap.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                FB_WORDS  = DEF_FB_WORDS,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              Clk,
    input  logic              reset_rtl_0,
    input  logic              vsync,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              rast_req,
    input  logic [ADDR_W-1:0] rast_addr,
    input  logic [DATA_W-1:0] rast_wdata,
    output logic              rast_gnt,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_sel,
    output logic              clr_busy,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    fb_state_t         state_q;
    logic              vsync_q;
    logic              front_sel_q;
    logic              swap_pending_q;
    logic              scan_rvalid_q;
    logic              clr_busy_q;
    logic [ADDR_W:0]   addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              vs_rise;
    logic              flip;
    logic              clr_we;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;

    assign vs_rise = vsync & ~vsync_q;
    assign flip    = (state_q == WAIT_VS) & vs_rise;

    assign scan_gnt     = scan_req;
    assign scan_rvalid  = scan_rvalid_q;
    assign scan_rdata   = mem_rdata;
    assign swap_pending = swap_pending_q;
    assign swap_done    = flip;
    assign front_sel    = front_sel_q;
    assign clr_busy     = clr_busy_q;

    // Gating on reset keeps the BRAM untouched while reset is held.
    assign rast_gnt = rast_req & ~scan_req & (state_q == IDLE)
                    & reset_rtl_0;

`ifdef FB_CLEAR_EN
    assign clr_we = (state_q == CLEAR) & ~scan_req & reset_rtl_0;

    fb_clear_engine #(
        .ADDR_W   (ADDR_W),
        .FB_WORDS (FB_WORDS)
    ) u_clear (
        .clk_i     (Clk),
        .rst_ni    (reset_rtl_0),
        .start_i   (flip),
        .advance_i (clr_we),
        .addr_o    (clr_addr),
        .done_o    (clr_done)
    );
`else
    logic unused_cfg;

    assign clr_we     = 1'b0;
    assign clr_done   = 1'b0;
    assign clr_addr   = '0;
    assign unused_cfg = ^CLEAR_VAL ^ (FB_WORDS > 0);
`endif

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        if (scan_req) begin
            mem_addr = {front_sel_q, scan_addr};
        end else if (clr_we) begin
            mem_addr  = {~front_sel_q, clr_addr};
            mem_wdata = CLEAR_VAL;
            mem_we    = 1'b1;
        end else if (rast_gnt) begin
            mem_addr  = {~front_sel_q, rast_addr};
            mem_wdata = rast_wdata;
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            vsync_q       <= 1'b0;
            scan_rvalid_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            vsync_q       <= vsync;
            scan_rvalid_q <= scan_gnt;
            addr_q        <= mem_addr;
            wdata_q       <= mem_wdata;
        end
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q        <= IDLE;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            clr_busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (swap_req) begin
                        state_q        <= WAIT_VS;
                        swap_pending_q <= 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (vs_rise) begin
                        front_sel_q    <= ~front_sel_q;
                        swap_pending_q <= 1'b0;
`ifdef FB_CLEAR_EN
                        state_q        <= CLEAR;
                        clr_busy_q     <= 1'b1;
`else
                        state_q        <= IDLE;
`endif
                    end
                end
                CLEAR: begin
                    if (clr_done) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: vector table, corner sequences
// and a randomized run against a bank/queue-level reference model.
module tb_fb_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int NW = 76800;
`ifdef FB_CLEAR_EN
    localparam bit SWAP_OK = 1'b0;
`else
    localparam bit SWAP_OK = 1'b1;
`endif

    logic          Clk = 1'b0;
    logic          reset_rtl_0;
    logic          vsync;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_gnt;
    logic          scan_rvalid;
    logic [DW-1:0] scan_rdata;
    logic          rast_req;
    logic [AW-1:0] rast_addr;
    logic [DW-1:0] rast_wdata;
    logic          rast_gnt;
    logic          swap_req;
    logic          swap_pending;
    logic          swap_done;
    logic          front_sel;
    logic          clr_busy;
    logic [AW:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    fb_arbiter dut (
        .Clk          (Clk),
        .reset_rtl_0  (reset_rtl_0),
        .vsync        (vsync),
        .scan_req     (scan_req),
        .scan_addr    (scan_addr),
        .scan_gnt     (scan_gnt),
        .scan_rvalid  (scan_rvalid),
        .scan_rdata   (scan_rdata),
        .rast_req     (rast_req),
        .rast_addr    (rast_addr),
        .rast_wdata   (rast_wdata),
        .rast_gnt     (rast_gnt),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .front_sel    (front_sel),
        .clr_busy     (clr_busy),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Frame memory with 1-cycle read latency and a bench preload port.
    logic [DW-1:0] bram [0:(1<<(AW+1))-1] = '{default: '0};
    logic          pre_we;
    logic [AW:0]   pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge Clk) begin
        if (pre_we) bram[pre_addr] <= pre_data;
        else if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic          sr;
        logic [AW-1:0] sa;
        logic          rr;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          eg_s;
        logic          eg_r;
        logic          ewe;
        logic [AW:0]   ea;
    } vec_t;

    function automatic vec_t mkv(logic sr, logic [AW-1:0] sa, logic rr,
                                 logic [AW-1:0] ra, logic [DW-1:0] rd,
                                 logic gs, logic gr, logic we,
                                 logic [AW:0] ea);
        vec_t v;
        v.sr = sr; v.sa = sa; v.rr = rr; v.ra = ra; v.rd = rd;
        v.eg_s = gs; v.eg_r = gr; v.ewe = we; v.ea = ea;
        return v;
    endfunction

    vec_t vt[$];

    // Reference model state
    logic          m_front, m_pend, m_vsq, m_rv, m_av, m_wv, g_prev;
    logic [AW:0]   m_addr;
    logic [DW-1:0] m_wd, m_rdat;
    logic [DW-1:0] m_mem [int];

    initial begin
        int viol, wr_ok, wr_bad, k;
        logic          e_rg, e_done, e_we;
        logic [AW:0]   e_addr;
        logic [DW-1:0] e_wd;

        reset_rtl_0 = 1'b0; vsync = 1'b0; swap_req = 1'b0;
        scan_req = 1'b0; scan_addr = '0;
        rast_req = 1'b1; rast_addr = 17'h55; rast_wdata = 8'h77;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        #1;

        // Reset held with a write pending
        repeat (3) begin
            @(negedge Clk);
            chk("rst_we", mem_we, 0);
            chk("rst_rgnt", rast_gnt, 0);
            nxt();
        end
        chk("rst_front", front_sel, 0);
        chk("rst_pend", swap_pending, 0);
        chk("rst_done", swap_done, 0);
        chk("rst_rvalid", scan_rvalid, 0);
        chk("rst_clr", clr_busy, 0);
        reset_rtl_0 = 1'b1;
        rast_req = 1'b0;
        @(negedge Clk);
        chk("post_rst_we", mem_we, 0);
        chk("post_rst_front", front_sel, 0);
        nxt();

        // Arbitration vectors, front bank 0
        vt.push_back(mkv(1, 5,       1, 9,       8'h3C, 1, 0, 0, 18'h00005));
        vt.push_back(mkv(0, 0,       1, 9,       8'h3C, 0, 1, 1, 18'h20009));
        vt.push_back(mkv(0, 0,       0, 0,       8'h00, 0, 0, 0, 18'h20009));
        vt.push_back(mkv(1, 17'h1FFFF, 0, 0,     8'h00, 1, 0, 0, 18'h1FFFF));
        vt.push_back(mkv(0, 0,       1, 17'h1FFFF, 8'hFF, 0, 1, 1, 18'h3FFFF));
        vt.push_back(mkv(1, 0,       1, 3,       8'h11, 1, 0, 0, 18'h00000));
        vt.push_back(mkv(0, 0,       1, 3,       8'h11, 0, 1, 1, 18'h20003));
        vt.push_back(mkv(0, 0,       0, 0,       8'h00, 0, 0, 0, 18'h20003));
        foreach (vt[i]) begin
            scan_req = vt[i].sr; scan_addr = vt[i].sa;
            rast_req = vt[i].rr; rast_addr = vt[i].ra;
            rast_wdata = vt[i].rd;
            @(negedge Clk);
            chk($sformatf("v%0d_sgnt", i), scan_gnt, vt[i].eg_s);
            chk($sformatf("v%0d_rgnt", i), rast_gnt, vt[i].eg_r);
            chk($sformatf("v%0d_we", i), mem_we, vt[i].ewe);
            chk($sformatf("v%0d_addr", i), mem_addr, vt[i].ea);
            if (vt[i].ewe)
                chk($sformatf("v%0d_wd", i), mem_wdata, vt[i].rd);
            nxt();
        end
        scan_req = 1'b0; rast_req = 1'b0;

        // Read latency
        pre_we = 1'b1; pre_addr = {1'b0, 17'd100}; pre_data = 8'hA5;
        nxt();
        pre_we = 1'b0;
        scan_req = 1'b1; scan_addr = 17'd100;
        @(negedge Clk);
        chk("rd_gnt", scan_gnt, 1);
        chk("rd_addr", mem_addr, {1'b0, 17'd100});
        chk("rd_rvalid_n", scan_rvalid, 0);
        nxt();
        scan_req = 1'b0;
        @(negedge Clk);
        chk("rd_rvalid", scan_rvalid, 1);
        chk("rd_data", scan_rdata, 8'hA5);
        nxt();
        @(negedge Clk);
        chk("rd_rvalid_off", scan_rvalid, 0);
        nxt();

        // swap_req coinciding with a vsync rise
        swap_req = 1'b1; vsync = 1'b1;
        @(negedge Clk);
        chk("sim_nodone", swap_done, 0);
        nxt();
        swap_req = 1'b0;
        @(negedge Clk);
        chk("sim_pend", swap_pending, 1);
        chk("sim_front0", front_sel, 0);
        nxt();
        vsync = 1'b0; swap_req = 1'b1;
        nxt();
        swap_req = 1'b0;
        @(negedge Clk);
        chk("sim_wait_done", swap_done, 0);
        nxt();
        vsync = 1'b1; scan_req = 1'b1; scan_addr = 17'h33;
        @(negedge Clk);
        chk("sim_flip_done", swap_done, 1);
        chk("sim_flip_addr", mem_addr, {1'b0, 17'h33});
        nxt();
        @(negedge Clk);
        chk("sim_after_done", swap_done, 0);
        chk("sim_after_front", front_sel, 1);
        chk("sim_after_pend", swap_pending, 0);
        chk("sim_after_addr", mem_addr, {1'b1, 17'h33});
        nxt();
        scan_req = 1'b0; vsync = 1'b0;
        nxt();
        vsync = 1'b1;
        @(negedge Clk);
        chk("sim_no_double", swap_done, 0);
        nxt();
        @(negedge Clk);
        chk("sim_front_keep", front_sel, 1);
        nxt();
        vsync = 1'b0;

        // Reset in the middle of a swap sequence
`ifdef FB_CLEAR_EN
        rast_req = 1'b1;
        @(negedge Clk);
        chk("clr_busy_on", clr_busy, 1);
        chk("clr_rblock", rast_gnt, 0);
        nxt();
`else
        swap_req = 1'b1;
        nxt();
        swap_req = 1'b0;
        @(negedge Clk);
        chk("mid_pend", swap_pending, 1);
        nxt();
`endif
        reset_rtl_0 = 1'b0; rast_req = 1'b1;
        @(negedge Clk);
        chk("mid_front", front_sel, 0);
        chk("mid_pend0", swap_pending, 0);
        chk("mid_clr", clr_busy, 0);
        chk("mid_we", mem_we, 0);
        nxt();
        reset_rtl_0 = 1'b1; rast_req = 1'b0;
        nxt();

        // Swap with vsync 50 cycles after the request
        swap_req = 1'b1;
        nxt();
        swap_req = 1'b0;
        rast_req = 1'b1; rast_addr = 17'd7; rast_wdata = 8'h42;
        viol = 0;
        for (int c = 1; c < 50; c++) begin
            @(negedge Clk);
            if (swap_pending !== 1'b1 || rast_gnt !== 1'b0 ||
                swap_done !== 1'b0) viol++;
            nxt();
        end
        chk("sw_wait_viol", viol, 0);
        vsync = 1'b1;
        @(negedge Clk);
        chk("sw_done", swap_done, 1);
        chk("sw_edge_rblock", rast_gnt, 0);
        nxt();
        @(negedge Clk);
        chk("sw_front", front_sel, 1);
        chk("sw_pend0", swap_pending, 0);
`ifdef FB_CLEAR_EN
        chk("sw_clr_busy", clr_busy, 1);
        nxt();
        wr_ok = 0; wr_bad = 0; viol = 0; k = 0;
        while (k < 90000) begin
            scan_req = (k % 16 == 0);
            @(negedge Clk);
            if (!clr_busy) break;
            if (rast_gnt) viol++;
            if (mem_we) begin
                if (mem_addr === {1'b0, AW'(wr_ok)} && mem_wdata === 8'h00)
                    wr_ok++;
                else
                    wr_bad++;
            end
            nxt();
            k++;
        end
        chk("clr_timeout", (k < 90000), 1);
        chk("clr_count", wr_ok, NW);
        chk("clr_bad", wr_bad, 0);
        chk("clr_rblock_viol", viol, 0);
        nxt();
        scan_req = 1'b0;
        @(negedge Clk);
`endif
        chk("sw_rgnt", rast_gnt, 1);
        chk("sw_waddr", mem_addr, {1'b0, 17'd7});
        chk("sw_we", mem_we, 1);
        chk("sw_wd", mem_wdata, 8'h42);
        nxt();
        rast_req = 1'b0; vsync = 1'b0;

        // Randomized run against the reference model
        reset_rtl_0 = 1'b0;
        nxt();
        nxt();
        reset_rtl_0 = 1'b1;
        m_front = 0; m_pend = 0; m_vsq = 0; m_rv = 0;
        m_av = 0; m_wv = 0; g_prev = 0;
        m_addr = '0; m_wd = '0; m_rdat = '0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom % 6 == 0) vsync = ~vsync;
            swap_req = SWAP_OK && ($urandom % 20 == 0);
            scan_req = ($urandom % 3 == 0);
            scan_addr = 17'h1000 + 17'($urandom % 16);
            if (!rast_req || g_prev) begin
                rast_req = $urandom % 2;
                rast_addr = 17'h1000 + 17'($urandom % 16);
                rast_wdata = 8'($urandom);
            end
            @(negedge Clk);
            e_rg = rast_req && !scan_req && !m_pend;
            e_done = m_pend && vsync && !m_vsq;
            e_we = 1'b0; e_addr = m_addr; e_wd = m_wd;
            if (scan_req) begin
                e_addr = {m_front, scan_addr};
            end else if (e_rg) begin
                e_addr = {~m_front, rast_addr};
                e_wd = rast_wdata; e_we = 1'b1;
            end
            chk("r_sgnt", scan_gnt, scan_req);
            chk("r_rgnt", rast_gnt, e_rg);
            chk("r_we", mem_we, e_we);
            chk("r_done", swap_done, e_done);
            chk("r_pend", swap_pending, m_pend);
            chk("r_front", front_sel, m_front);
            chk("r_rvalid", scan_rvalid, m_rv);
            chk("r_clr", clr_busy, 0);
            if (scan_req || e_rg || m_av) chk("r_addr", mem_addr, e_addr);
            if (e_we || m_wv) chk("r_wd", mem_wdata, e_wd);
            if (m_rv) chk("r_rdata", scan_rdata, m_rdat);
            if (scan_req)
                m_rdat = m_mem.exists(int'(e_addr)) ? m_mem[int'(e_addr)] : '0;
            if (e_we) m_mem[int'(e_addr)] = e_wd;
            m_rv = scan_req;
            m_av = m_av || scan_req || e_rg;
            m_wv = m_wv || e_we;
            m_addr = e_addr; m_wd = e_wd;
            g_prev = e_rg;
            if (e_done) begin
                m_front = ~m_front; m_pend = 1'b0;
            end else if (!m_pend && swap_req) begin
                m_pend = 1'b1;
            end
            m_vsq = vsync;
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
